// File: rtl/router_wrap_pkg.sv
// Shared router_wrap types and constants: skid-stage state encoding and default flit width.
`timescale 1ns/1ps
package router_wrap_pkg;

    localparam int unsigned ROUTER_FLIT_W = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } skid_state_t;

endpackage

// File: rtl/router_ovalid_skid_ch.sv
// One router output channel: 2-entry skid register with a registered-only ready/valid and a
// saturating stall counter.
`timescale 1ns/1ps
module router_ovalid_skid_ch
    import router_wrap_pkg::*;
#(
    parameter int unsigned DATA_W = ROUTER_FLIT_W,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    skid_state_t       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push, pop;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (push) state_d = ONE;
                ONE: begin
                    if (push && !pop) begin
                        state_d = TWO;
                    end else if (!push && pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO:     if (pop) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Handshake outputs decode state only, so there is no combinational path from out_ready.
    always_comb begin
        out_valid = (state_q != EMPTY);
        in_ready  = (state_q != TWO);
    end

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (!flush) begin
            case (state_q)
                EMPTY: if (push) main_d = in_data;
                ONE: begin
                    if (push && pop) begin
                        main_d = in_data;
                    end else if (push) begin
                        skid_d = in_data;
                    end
                end
                TWO:     if (pop) main_d = skid_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (out_valid && !out_ready && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q <= '0;
            skid_q <= '0;
            cnt_q  <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_data  = main_q;
    assign stall_cnt = cnt_q;

endmodule

// File: rtl/router_ovalid_skid_reg.sv
// NUM_CH independent router output channels, each registered through a 2-entry skid stage.
`timescale 1ns/1ps
module router_ovalid_skid_reg
    import router_wrap_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = ROUTER_FLIT_W,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic [NUM_CH-1:0]        out_valid,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*CNT_W-1:0]  stall_cnt
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        router_ovalid_skid_ch #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (in_valid[c]),
            .in_data   (in_data[c*DATA_W +: DATA_W]),
            .in_ready  (in_ready[c]),
            .out_valid (out_valid[c]),
            .out_data  (out_data[c*DATA_W +: DATA_W]),
            .out_ready (out_ready[c]),
            .stall_cnt (stall_cnt[c*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_router_ovalid_skid_reg.sv
// Bench for router_ovalid_skid_reg: each channel modelled as a depth-2 FIFO queue with a
// saturating stall count; a negedge monitor compares the DUT against the queues.
`timescale 1ns/1ps
module tb_router_ovalid_skid_reg;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     flush;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic [NUM_CH-1:0]        out_ready;
    logic [NUM_CH*CNT_W-1:0]  stall_cnt;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] sbq [NUM_CH][$];
    int                mcnt [NUM_CH];

    always #5 clk = ~clk;

    router_ovalid_skid_reg #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .stall_cnt (stall_cnt)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a channel is a FIFO holding at most two flits.
    always @(posedge clk or negedge reset) begin
        if (!reset || flush) begin
            for (int c = 0; c < NUM_CH; c++) begin
                sbq[c].delete();
                mcnt[c] = 0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                int  occ;
                bit  acc, take;
                occ  = sbq[c].size();
                acc  = in_valid[c] && (occ < 2);
                take = (occ > 0) && out_ready[c];
                if (occ > 0 && !out_ready[c] && mcnt[c] < CMAX) mcnt[c]++;
                if (take) void'(sbq[c].pop_front());
                if (acc) sbq[c].push_back(in_data[c*DATA_W +: DATA_W]);
            end
        end
    end

    always @(negedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            int occ;
            occ = sbq[c].size();
            check($sformatf("mon_out_valid[%0d]", c), 64'(out_valid[c]), 64'(occ > 0));
            check($sformatf("mon_in_ready[%0d]", c), 64'(in_ready[c]), 64'(occ < 2));
            check($sformatf("mon_stall_cnt[%0d]", c), 64'(stall_cnt[c*CNT_W +: CNT_W]),
                  64'(mcnt[c]));
            if (occ > 0) begin
                check($sformatf("mon_out_data[%0d]", c), 64'(out_data[c*DATA_W +: DATA_W]),
                      64'(sbq[c][0]));
            end
        end
    end

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '0;

        // Reset then idle
        repeat (3) tick();
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_data", 64'(out_data), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'hF);
        check("rst_stall_cnt", 64'(stall_cnt), 64'h0);
        reset = 1'b1;
        repeat (3) tick();
        check("idle_out_valid", 64'(out_valid), 64'h0);
        check("idle_out_data", 64'(out_data), 64'h0);
        check("idle_in_ready", 64'(in_ready), 64'hF);

        // Streaming on ch0 with no bubbles
        out_ready = '1;
        for (int i = 1; i <= 100; i++) begin
            in_valid[0]         = 1'b1;
            in_data[DATA_W-1:0] = DATA_W'(i);
            tick();
            check("stream_data", 64'(out_data[DATA_W-1:0]), 64'(i));
            check("stream_in_ready", 64'(in_ready[0]), 64'h1);
            check("stream_valid", 64'(out_valid[0]), 64'h1);
        end
        in_valid = '0;
        repeat (3) tick();

        // Backpressure: A then B held, then released
        out_ready = '0;
        in_valid[0] = 1'b1;
        in_data[DATA_W-1:0] = 32'hA0A0_0001;
        tick();
        in_data[DATA_W-1:0] = 32'hB0B0_0002;
        tick();
        in_valid = '0;
        check("bp_in_ready_full", 64'(in_ready[0]), 64'h0);
        check("bp_head_a", 64'(out_data[DATA_W-1:0]), 64'hA0A0_0001);
        out_ready[0] = 1'b1;
        tick();
        check("bp_then_b", 64'(out_data[DATA_W-1:0]), 64'hB0B0_0002);
        check("bp_in_ready_back", 64'(in_ready[0]), 64'h1);
        tick();
        check("bp_drained", 64'(out_valid[0]), 64'h0);

        // Asynchronous reset with ch0 holding two flits
        out_ready = '0;
        in_valid[0] = 1'b1;
        in_data[DATA_W-1:0] = 32'h1111_1111;
        tick();
        in_data[DATA_W-1:0] = 32'h2222_2222;
        tick();
        in_valid = '0;
        check("ar_pre_full", 64'(in_ready[0]), 64'h0);
        #2;
        reset = 1'b0;
        #1;
        check("ar_out_valid", 64'(out_valid), 64'h0);
        check("ar_out_data", 64'(out_data), 64'h0);
        check("ar_in_ready", 64'(in_ready), 64'hF);
        check("ar_stall_cnt", 64'(stall_cnt), 64'h0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("ar_post_valid", 64'(out_valid), 64'h0);

        // Stall counter saturation on ch0
        in_valid[0] = 1'b1;
        in_data[DATA_W-1:0] = 32'h0000_0007;
        tick();
        in_valid = '0;
        repeat (270) tick();
        check("sat_cnt", 64'(stall_cnt[CNT_W-1:0]), 64'(CMAX));
        repeat (10) tick();
        check("sat_hold", 64'(stall_cnt[CNT_W-1:0]), 64'(CMAX));
        check("sat_data", 64'(out_data[DATA_W-1:0]), 64'h7);

        // Flush: ch1 full, ch2 one flit, ch3 push coinciding with flush
        in_valid = 4'b0110;
        in_data[1*DATA_W +: DATA_W] = 32'hC1C1_0001;
        in_data[2*DATA_W +: DATA_W] = 32'hC2C2_0001;
        tick();
        in_valid = 4'b0010;
        in_data[1*DATA_W +: DATA_W] = 32'hC1C1_0002;
        tick();
        check("fl_ch1_full", 64'(in_ready[1]), 64'h0);
        check("fl_ch2_one", 64'(out_valid[2]), 64'h1);
        in_valid = 4'b1000;
        in_data[3*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = '0;
        check("fl_out_valid", 64'(out_valid), 64'h0);
        check("fl_stall_cnt", 64'(stall_cnt), 64'h0);
        check("fl_in_ready", 64'(in_ready), 64'hF);
        out_ready = '1;
        repeat (4) tick();
        check("fl_ch3_dropped", 64'(out_valid), 64'h0);

        // Random independent traffic with rare flushes
        for (int n = 0; n < 10000; n++) begin
            in_valid  = 4'($urandom);
            out_ready = 4'($urandom);
            flush     = ($urandom_range(0, 499) == 0);
            for (int c = 0; c < NUM_CH; c++) in_data[c*DATA_W +: DATA_W] = $urandom;
            tick();
        end
        flush     = 1'b0;
        in_valid  = '0;
        out_ready = '1;
        repeat (4) tick();
        check("end_drained", 64'(out_valid), 64'h0);
        check("end_in_ready", 64'(in_ready), 64'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
